// File: rtl/banco_registradores_if.sv
// Decode / write-back bundle for the banco_registradores register file.
// master = pipeline side driving indices and strobes; slave = the register file.
interface banco_registradores_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] rs_addr;
   logic [ADDR_W-1:0] rt_addr;
   logic [DATA_W-1:0] rs_data;
   logic [DATA_W-1:0] rt_data;
   logic              issue_valid;
   logic              issue_wr;
   logic [ADDR_W-1:0] issue_dst;
   logic              stall;
   logic              wb_en;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;

   modport master (
      output rs_addr, rt_addr, issue_valid, issue_wr, issue_dst, wb_en, wb_addr, wb_data,
      input  rs_data, rt_data, stall
   );

   modport slave (
      input  rs_addr, rt_addr, issue_valid, issue_wr, issue_dst, wb_en, wb_addr, wb_data,
      output rs_data, rt_data, stall
   );
endinterface

// File: rtl/banco_registradores.sv
// MIPS register file with pending-write scoreboard; 0-cycle reads and stall, writes land on the next edge.
// Optional BANCO_BYPASS_EN forwards wb_data to reads and clears the hazard in the write-back cycle.
module banco_registradores #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   banco_registradores_if.slave  bus
);
   localparam int NREGS = 1 << ADDR_W;

   logic [DATA_W-1:0] regs [NREGS];
   logic [NREGS-1:0]  pending;
   logic [NREGS-1:0]  hit_vec;
   logic [NREGS-1:0]  set_vec;
   logic [NREGS-1:0]  busy;
   logic              accept;
   logic              stall_c;
   logic [DATA_W-1:0] rs_val;
   logic [DATA_W-1:0] rt_val;

   // Bit 0 of hit_vec/set_vec is never set, so register 0 stays zero and never pending.
   always_comb begin
      hit_vec = '0;
      if (bus.wb_en && bus.wb_addr != '0)
         hit_vec[bus.wb_addr] = 1'b1;
   end

`ifdef BANCO_BYPASS_EN
   assign busy = pending & ~hit_vec;
`else
   assign busy = pending;
`endif

   assign stall_c = bus.issue_valid &
                    (busy[bus.rs_addr] | busy[bus.rt_addr] |
                     (bus.issue_wr & busy[bus.issue_dst]));
   assign accept  = bus.issue_valid & ~stall_c;

   always_comb begin
      set_vec = '0;
      if (accept && bus.issue_wr && bus.issue_dst != '0)
         set_vec[bus.issue_dst] = 1'b1;
   end

   always_comb begin
      rs_val = regs[bus.rs_addr];
      rt_val = regs[bus.rt_addr];
`ifdef BANCO_BYPASS_EN
      // Forwarding is gated by rst_n so reads stay zero while reset is held.
      if (rst_n && hit_vec[bus.rs_addr])
         rs_val = bus.wb_data;
      if (rst_n && hit_vec[bus.rt_addr])
         rt_val = bus.wb_data;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++)
            regs[i] <= '0;
         pending <= '0;
      end else begin
         for (int i = 1; i < NREGS; i++)
            if (hit_vec[i])
               regs[i] <= bus.wb_data;
         // A new producer issued alongside the retiring write keeps the bit set.
         pending <= (pending & ~hit_vec) | set_vec;
      end
   end

   assign bus.rs_data = rs_val;
   assign bus.rt_data = rt_val;
   assign bus.stall   = stall_c;
endmodule
